// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the fetch front-end state encoding.
// Opcode constants are also consumed by the decode controller.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE) ||
               (op == OP_REG)  || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, result held until decode takes it; 3 cycles/instr best case.
// Request holds until accepted; instr holds while instr_ready=0; redirect flushes and drops in-flight data.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic            op_5,
    output logic            instr_illegal,
    output logic            fetch_misaligned
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_drop, w_drop_nxt;
    logic            r_instr_valid, w_instr_valid_nxt;
    logic [31:0]     r_instr, w_instr_nxt;
    logic [XLEN-1:0] r_instr_pc, w_instr_pc_nxt;
    logic            r_misaligned, w_misaligned_nxt;
    logic            w_req_hs;

    assign w_req_hs = (r_state == FETCH_REQ) && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH_REQ;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_misaligned  <= w_misaligned_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_misaligned_nxt  = 1'b0;

        case (r_state)
            FETCH_REQ: begin
                if (w_req_hs) w_state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = FETCH_REQ;
                    end else begin
                        w_instr_nxt       = imem_rsp_data;
                        w_instr_pc_nxt    = r_pc;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_nxt          = r_pc + XLEN'(4);
                        w_state_nxt       = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (r_instr_valid && instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = FETCH_REQ;
                end
            end
            default: w_state_nxt = FETCH_REQ;
        endcase

        // Redirect overrides everything above; a response landing this cycle is wrong-path.
        if (redirect_valid) begin
            w_pc_nxt         = {redirect_target[XLEN-1:2], 2'b00};
            w_misaligned_nxt = |redirect_target[1:0];
            w_instr_nxt      = r_instr;
            w_instr_pc_nxt   = r_instr_pc;
            case (r_state)
                FETCH_REQ: begin
                    if (w_req_hs) begin
                        w_state_nxt = FETCH_WAIT;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FETCH_REQ;
                    end
                end
                FETCH_WAIT: begin
                    w_instr_valid_nxt = 1'b0;
                    if (imem_rsp_valid) begin
                        w_state_nxt = FETCH_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = FETCH_WAIT;
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = FETCH_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid   = (r_state == FETCH_REQ);
    assign imem_req_addr    = r_pc;
    assign instr_valid      = r_instr_valid;
    assign instr            = r_instr;
    assign instr_pc         = r_instr_pc;
    assign opcode           = r_instr[6:0];
    assign funct3           = r_instr[14:12];
    assign funct7_5         = r_instr[30];
    assign op_5             = r_instr[5];
    assign instr_illegal    = r_instr_valid && !is_legal_opcode(r_instr[6:0]);
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency plus a second
// instance reset near the top of the address space to exercise PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        op_5;
    logic        instr_illegal;
    logic        fetch_misaligned;

    logic        hi_req_valid;
    logic [63:0] hi_req_addr;
    logic        hi_rsp_valid;
    logic [31:0] hi_rsp_data;
    logic        hi_instr_valid;
    logic        hi_instr_ready;
    logic [31:0] hi_instr;
    logic [63:0] hi_instr_pc;
    logic [6:0]  hi_opcode;
    logic [2:0]  hi_funct3;
    logic        hi_funct7_5;
    logic        hi_op_5;
    logic        hi_illegal;
    logic        hi_misaligned;

    int          n_total;
    int          n_pass;
    int          mem_lat;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic        seen;

    fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .op_5(op_5),
        .instr_illegal(instr_illegal), .fetch_misaligned(fetch_misaligned)
    );

    fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_hi (
        .clk(clk), .rst(rst),
        .imem_req_valid(hi_req_valid), .imem_req_addr(hi_req_addr),
        .imem_req_ready(1'b1),
        .imem_rsp_valid(hi_rsp_valid), .imem_rsp_data(hi_rsp_data),
        .redirect_valid(1'b0), .redirect_target(64'h0),
        .instr_valid(hi_instr_valid), .instr_ready(hi_instr_ready),
        .instr(hi_instr), .instr_pc(hi_instr_pc),
        .opcode(hi_opcode), .funct3(hi_funct3), .funct7_5(hi_funct7_5), .op_5(hi_op_5),
        .instr_illegal(hi_illegal), .fetch_misaligned(hi_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        case (a)
            64'h000: return 32'h00500093;
            64'h004: return 32'h40208133;
            64'h008: return 32'h00C00193;
            64'h100: return 32'h0000007F;
            64'h200: return 32'h00209463;
            default: return 32'h00000013;
        endcase
    endfunction

    // Memory model: responds mem_lat cycles after the accepting edge; cleared by rst.
    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word_at(mem_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_cnt  = mem_lat;
                mem_addr = imem_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_instr(input string tag);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check(tag, instr_valid, 1'b1);
    endtask

    task automatic redirect(input logic [63:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_total = 0; n_pass = 0;
        clk = 1'b0; rst = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_data = '0; mem_lat = 1; mem_cnt = 0; mem_addr = '0;
        redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
        hi_rsp_valid = 1'b0; hi_rsp_data = '0; hi_instr_ready = 1'b0;

        tick(); tick();
        check("rst_req_vld", imem_req_valid, 1'b1);
        check("rst_req_addr", imem_req_addr, 64'h0);
        check("rst_ivld", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h00000013);
        check("rst_ipc", instr_pc, 64'h0);
        check("rst_opcode", opcode, 7'b0010011);
        check("rst_funct3", funct3, 3'd0);
        check("rst_f7_5", funct7_5, 1'b0);
        check("rst_op5", op_5, 1'b0);
        check("rst_illegal", instr_illegal, 1'b0);
        check("rst_misal", fetch_misaligned, 1'b0);
        check("hi_rst_addr", hi_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        rst = 1'b0;

        tick();
        check("f0_wait_noreq", imem_req_valid, 1'b0);
        hi_rsp_valid = 1'b1;
        hi_rsp_data  = 32'h00000013;
        tick();
        hi_rsp_valid = 1'b0;
        check("f0_ivld", instr_valid, 1'b1);
        check("f0_instr", instr, 32'h00500093);
        check("f0_ipc", instr_pc, 64'h0);
        check("f0_opcode", opcode, 7'b0010011);
        check("f0_illegal", instr_illegal, 1'b0);
        check("f0_hold_noreq", imem_req_valid, 1'b0);
        check("hi_ivld", hi_instr_valid, 1'b1);
        check("hi_ipc", hi_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        instr_ready = 1'b1; hi_instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; hi_instr_ready = 1'b0;
        check("f1_req_vld", imem_req_valid, 1'b1);
        check("f1_req_addr", imem_req_addr, 64'h4);
        check("f1_consumed", instr_valid, 1'b0);
        check("hi_wrap_vld", hi_req_valid, 1'b1);
        check("hi_wrap_addr", hi_req_addr, 64'h0);

        wait_instr("f1_timeout");
        check("f1_instr", instr, 32'h40208133);
        check("f1_ipc", instr_pc, 64'h4);
        check("f1_opcode", opcode, 7'b0110011);
        check("f1_f7_5", funct7_5, 1'b1);
        check("f1_op5", op_5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ivld", instr_valid, 1'b1);
            check("stall_noreq", imem_req_valid, 1'b0);
        end
        check("stall_instr", instr, 32'h40208133);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("f2_req_vld", imem_req_valid, 1'b1);
        check("f2_req_addr", imem_req_addr, 64'h8);

        mem_lat = 3;
        tick();
        check("f2_wait", imem_req_valid, 1'b0);
        redirect(64'h100);
        mem_lat = 1;
        check("rdw_stay_wait", imem_req_valid, 1'b0);
        seen = instr_valid;
        for (int i = 0; i < 20 && !imem_req_valid; i++) begin
            tick();
            if (instr_valid) seen = 1'b1;
        end
        check("rdw_req_vld", imem_req_valid, 1'b1);
        check("rdw_dropped", seen, 1'b0);
        check("rdw_req_addr", imem_req_addr, 64'h100);

        wait_instr("f100_timeout");
        check("f100_instr", instr, 32'h0000007F);
        check("f100_ipc", instr_pc, 64'h100);
        check("f100_illegal", instr_illegal, 1'b1);

        instr_ready = 1'b1;
        redirect(64'h200);
        instr_ready = 1'b0;
        check("rdh_flush", instr_valid, 1'b0);
        check("rdh_req_vld", imem_req_valid, 1'b1);
        check("rdh_req_addr", imem_req_addr, 64'h200);
        check("rdh_illegal_qual", instr_illegal, 1'b0);
        check("rdh_misal", fetch_misaligned, 1'b0);

        wait_instr("f200_timeout");
        check("f200_ipc", instr_pc, 64'h200);
        check("f200_opcode", opcode, 7'b1100011);
        check("f200_funct3", funct3, 3'd1);
        check("f200_illegal", instr_illegal, 1'b0);

        mem_lat = 3;
        redirect(64'h102);
        check("mis_pulse", fetch_misaligned, 1'b1);
        check("mis_req_addr", imem_req_addr, 64'h100);
        check("mis_flush", instr_valid, 1'b0);
        tick();
        check("mis_clear", fetch_misaligned, 1'b0);
        check("mis_wait", imem_req_valid, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_req_vld", imem_req_valid, 1'b1);
        check("rstw_req_addr", imem_req_addr, 64'h0);
        check("rstw_instr", instr, 32'h00000013);
        check("rstw_ivld", instr_valid, 1'b0);
        wait_instr("rstw_timeout");
        check("rstw_refetch", instr, 32'h00500093);
        check("rstw_ipc", instr_pc, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
